// File: rtl/truth_table_sampler.sv
// Sweeps every input pattern through a combinational circuit, records its output
// per pattern and compares the result against a golden truth table.
module truth_table_sampler #(
    parameter int NUM_PI = 4,
    parameter int SETTLE = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [(1<<NUM_PI)-1:0]   expected_tt,
    output logic [NUM_PI-1:0]        pi,
    input  logic                     po,
    output logic                     busy,
    output logic [(1<<NUM_PI)-1:0]   tt_out,
    output logic                     tt_valid,
    input  logic                     tt_ready,
    output logic [NUM_PI:0]          mismatch_cnt,
    output logic                     match
);

    localparam int TT_W = 1 << NUM_PI;
    localparam logic [NUM_PI-1:0] PI_LAST = '1;
    localparam logic [3:0] SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_HOLD
    } state_t;

    state_t              state, state_n;
    logic [TT_W-1:0]     exp_q, exp_n;
    logic [TT_W-1:0]     tt_out_n;
    logic [NUM_PI-1:0]   pi_n;
    logic [3:0]          settle_cnt, settle_cnt_n;
    logic [NUM_PI:0]     mismatch_n;
    logic                match_n;
    logic                busy_n;
    logic                tt_valid_n;
    logic                diff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            exp_q        <= '0;
            pi           <= '0;
            settle_cnt   <= '0;
            busy         <= 1'b0;
            tt_out       <= '0;
            tt_valid     <= 1'b0;
            mismatch_cnt <= '0;
            match        <= 1'b0;
        end else begin
            state        <= state_n;
            exp_q        <= exp_n;
            pi           <= pi_n;
            settle_cnt   <= settle_cnt_n;
            busy         <= busy_n;
            tt_out       <= tt_out_n;
            tt_valid     <= tt_valid_n;
            mismatch_cnt <= mismatch_n;
            match        <= match_n;
        end
    end

    // Every output is a flop fed from the next-state values computed here.
    always_comb begin
        state_n      = state;
        exp_n        = exp_q;
        pi_n         = pi;
        settle_cnt_n = settle_cnt;
        tt_out_n     = tt_out;
        mismatch_n   = mismatch_cnt;
        match_n      = match;
        diff         = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    exp_n        = expected_tt;
                    tt_out_n     = '0;
                    mismatch_n   = '0;
                    match_n      = 1'b0;
                    pi_n         = '0;
                    settle_cnt_n = '0;
                    state_n      = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    settle_cnt_n = '0;
                    state_n      = ST_SAMPLE;
                end else begin
                    settle_cnt_n = settle_cnt + 4'd1;
                end
            end
            ST_SAMPLE: begin
                diff         = po ^ exp_q[pi];
                tt_out_n[pi] = po;
                mismatch_n   = mismatch_cnt + {{NUM_PI{1'b0}}, diff};
                if (pi == PI_LAST) begin
                    match_n = (mismatch_n == '0);
                    state_n = ST_HOLD;
                end else begin
                    pi_n    = pi + 1'b1;
                    state_n = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
                end
            end
            ST_HOLD: begin
                // Start is deliberately not looked at here, even on the transfer cycle.
                if (tt_ready) begin
                    pi_n    = '0;
                    match_n = 1'b0;
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        busy_n     = (state_n == ST_SETTLE) || (state_n == ST_SAMPLE);
        tt_valid_n = (state_n == ST_HOLD);
    end

endmodule

// File: tb/tb_truth_table_sampler.sv
// Directed bench for truth_table_sampler; the sampled circuit is po = pi[2] & pi[3],
// whose truth table is 16'hF000.
module tb_truth_table_sampler;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] expected_tt;
    logic [3:0]  pi;
    logic        po;
    logic        busy;
    logic [15:0] tt_out;
    logic        tt_valid;
    logic        tt_ready;
    logic [4:0]  mismatch_cnt;
    logic        match;

    logic        start0;
    logic [15:0] expected0;
    logic [3:0]  pi0;
    logic        po0;
    logic        busy0;
    logic [15:0] tt_out0;
    logic        tt_valid0;
    logic        tt_ready0;
    logic [4:0]  mismatch0;
    logic        match0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] tt;
        int          cnt;
        logic        m;
    } vec_t;

    vec_t vecs[5];

    assign po  = pi[2] & pi[3];
    assign po0 = pi0[2] & pi0[3];

    truth_table_sampler #(.NUM_PI(4), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .expected_tt(expected_tt),
        .pi(pi), .po(po), .busy(busy), .tt_out(tt_out), .tt_valid(tt_valid),
        .tt_ready(tt_ready), .mismatch_cnt(mismatch_cnt), .match(match)
    );

    truth_table_sampler #(.NUM_PI(4), .SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .expected_tt(expected0),
        .pi(pi0), .po(po0), .busy(busy0), .tt_out(tt_out0), .tt_valid(tt_valid0),
        .tt_ready(tt_ready0), .mismatch_cnt(mismatch0), .match(match0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] tt);
        @(negedge clk);
        expected_tt = tt;
        start = 1'b1;
        @(posedge clk);
    endtask

    // Called right after the accepting edge; restartAt re-pulses start mid-sweep.
    task automatic watchSweep(input string name, input logic [15:0] tt, input int cnt,
                              input logic m, input int restartAt);
        int c;
        int busyLow;
        @(negedge clk);
        start = 1'b0;
        expected_tt = ~expected_tt;
        c = 1;
        busyLow = 0;
        while (!tt_valid && c < 200) begin
            if (!busy) busyLow++;
            start = (c == restartAt);
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        checkOutput({name, "_valid_cycle"}, c, 33);
        checkOutput({name, "_busy_gaps"}, busyLow, 0);
        checkOutput({name, "_busy_in_hold"}, busy, 0);
        checkOutput({name, "_tt_out"}, tt_out, tt);
        checkOutput({name, "_mismatch_cnt"}, mismatch_cnt, cnt);
        checkOutput({name, "_match"}, match, m);
    endtask

    // Transfer cycle with start asserted at the same time; start must not be honoured.
    task automatic doTransfer(input string name, input logic [15:0] tt);
        @(negedge clk);
        tt_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        tt_ready = 1'b0;
        start = 1'b0;
        checkOutput({name, "_xfer_valid"}, tt_valid, 0);
        checkOutput({name, "_xfer_busy"}, busy, 0);
        checkOutput({name, "_xfer_pi"}, pi, 0);
        checkOutput({name, "_xfer_match"}, match, 0);
        checkOutput({name, "_xfer_tt_kept"}, tt_out, tt);
        @(negedge clk);
        checkOutput({name, "_no_queued_start"}, busy, 0);
    endtask

    initial begin
        vecs[0] = '{tt: 16'hF000, cnt: 0,  m: 1'b1};
        vecs[1] = '{tt: 16'hF001, cnt: 1,  m: 1'b0};
        vecs[2] = '{tt: 16'h0FFF, cnt: 16, m: 1'b0};
        vecs[3] = '{tt: 16'h0000, cnt: 4,  m: 1'b0};
        vecs[4] = '{tt: 16'hFFFF, cnt: 12, m: 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        expected_tt = 16'h0;
        tt_ready = 1'b0;
        start0 = 1'b0;
        expected0 = 16'h0;
        tt_ready0 = 1'b0;

        #3;
        checkOutput("reset_pi", pi, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_valid", tt_valid, 0);
        checkOutput("reset_tt_out", tt_out, 0);
        checkOutput("reset_mismatch", mismatch_cnt, 0);
        checkOutput("reset_match", match, 0);

        // First start accepted on the very first edge after reset release.
        @(negedge clk);
        expected_tt = 16'hF000;
        start = 1'b1;
        rst_n = 1'b1;
        @(posedge clk);
        watchSweep("basic", 16'hF000, 0, 1'b1, -1);

        // Backpressure with start pulses while holding.
        for (int i = 0; i < 10; i++) begin
            start = (i == 3 || i == 6);
            @(negedge clk);
            checkOutput($sformatf("hold_valid_%0d", i), tt_valid, 1);
            checkOutput($sformatf("hold_tt_%0d", i), {busy, tt_out}, {1'b0, 16'hF000});
            checkOutput($sformatf("hold_cnt_%0d", i), {match, mismatch_cnt, pi}, {1'b1, 5'd0, 4'hF});
        end
        start = 1'b0;
        doTransfer("basic", 16'hF000);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].tt);
            watchSweep($sformatf("vec%0d", i), 16'hF000, vecs[i].cnt, vecs[i].m,
                       (i == 1) ? 5 : -1);
            doTransfer($sformatf("vec%0d", i), 16'hF000);
        end

        // Abort a sweep with reset at cycle 9.
        applyStimulus(16'h000F);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("pre_reset_pi", pi, 4);
        checkOutput("pre_reset_cnt", mismatch_cnt, 4);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_pi", pi, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_tt_out", tt_out, 0);
        checkOutput("abort_cnt", mismatch_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("post_abort_idle", {busy, tt_valid}, 2'b00);
        applyStimulus(16'hF000);
        watchSweep("after_reset", 16'hF000, 0, 1'b1, -1);
        doTransfer("after_reset", 16'hF000);

        // Zero-settle instance: one pattern per cycle.
        @(negedge clk);
        expected0 = 16'hF000;
        start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            checkOutput($sformatf("zs_pi_c%0d", c), {busy0, tt_valid0, pi0}, {2'b10, 4'(c - 1)});
            @(negedge clk);
        end
        checkOutput("zs_valid_c17", tt_valid0, 1);
        checkOutput("zs_tt_out", tt_out0, 16'hF000);
        checkOutput("zs_match", {match0, mismatch0}, {1'b1, 5'd0});
        tt_ready0 = 1'b1;
        @(negedge clk);
        tt_ready0 = 1'b0;
        checkOutput("zs_xfer", {tt_valid0, pi0}, 5'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/truth_table_sampler.md
TRUTH_TABLE_SAMPLER -- requirements
Module: truth_table_sampler

Interface
REQ-001 SHALL have parameter NUM_PI, default 4, meaning the number of primary inputs driven to the sampled circuit; legal range 1..6.
REQ-002 SHALL have parameter SETTLE, default 1, meaning the number of settle cycles per pattern before sampling; legal range 0..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: sweep request; honoured only in IDLE.
REQ-006 SHALL have port expected_tt, input, 2^NUM_PI bits: golden truth table, captured on an accepted start.
REQ-007 SHALL have port pi, output, NUM_PI bits: registered pattern driven to the combinational circuit under sample.
REQ-008 SHALL have port po, input, 1 bit: the circuit's output.
REQ-009 SHALL have port busy, output, 1 bit: high in SETTLE or SAMPLE.
REQ-010 SHALL have port tt_out, output, 2^NUM_PI bits: captured truth table; bit k = po observed with pi==k.
REQ-011 SHALL have port tt_valid, output, 1 bit: result available.
REQ-012 SHALL have port tt_ready, input, 1 bit: downstream accepts the result.
REQ-013 SHALL have port mismatch_cnt, output, NUM_PI+1 bits: number of positions k where tt_out[k] != expected bit k.
REQ-014 SHALL have port match, output, 1 bit: high when mismatch_cnt==0 and tt_valid is high.

Function
REQ-015 SHALL implement FSM states IDLE, SETTLE, SAMPLE, HOLD, with all outputs registered.
REQ-016 IDLE: start==1 -> capture expected_tt, clear tt_out and mismatch_cnt, set pi=0, go to SETTLE (or SAMPLE if SETTLE==0).
REQ-017 SETTLE: pi held; a settle counter counts SETTLE cycles, then the FSM goes to SAMPLE.
REQ-018 SAMPLE, one cycle:
- write po into tt_out[pi];
- increment mismatch_cnt if po differs from captured expected bit pi;
- if pi==2^NUM_PI-1 go to HOLD; else pi<=pi+1 and return to SETTLE (or stay in SAMPLE if SETTLE==0).
REQ-019 Each pattern SHALL take SETTLE+1 cycles; a full sweep SHALL take 2^NUM_PI*(SETTLE+1) cycles from the first cycle after start is accepted.
REQ-020 HOLD: tt_valid=1; tt_out, mismatch_cnt and match held stable; pi held at its last value.
REQ-021 HOLD: the cycle with tt_valid & tt_ready SHALL be the transfer; next cycle IDLE, tt_valid=0, pi=0; tt_out and mismatch_cnt retained until the next accepted start.
REQ-022 start SHALL be ignored in SETTLE, SAMPLE and HOLD, including when it coincides with the HOLD transfer cycle; it is not queued.
REQ-023 Changes on expected_tt after start is accepted SHALL NOT affect the result.
REQ-024 pi SHALL never exceed 2^NUM_PI-1 and SHALL NOT wrap within a sweep.
REQ-025 mismatch_cnt SHALL saturate-free cover 0..2^NUM_PI.

Reset
REQ-026 rst_n low SHALL force immediately, regardless of clk: state IDLE, pi=0, busy=0, tt_valid=0, tt_out=0, mismatch_cnt=0, match=0, settle counter=0.
REQ-027 A reset during a sweep SHALL abort it; no partial result is presented after rst_n rises.
REQ-028 The first start SHALL be accepted on the first rising edge with rst_n high.

Verification (NUM_PI=4, SETTLE=1 unless stated; bench model of the circuit: po = pi[2]&pi[3])
REQ-029 Basic sweep: expected_tt=16'hF000, start pulse accepted at edge 0 -> busy high for cycles 1..32, tt_valid high from cycle 33, tt_out=16'hF000, mismatch_cnt=0, match=1.
REQ-030 Mismatch counting: expected_tt=16'hF001 -> mismatch_cnt=1, match=0; expected_tt=16'h0FFF -> mismatch_cnt=16, match=0.
REQ-031 Backpressure: tt_ready low for 10 cycles in HOLD, with start pulsed during that time -> outputs stable and start ignored; tt_ready high -> IDLE next cycle, tt_valid=0.
REQ-032 Zero settle: SETTLE=0 -> pi steps 0..15 on consecutive cycles, tt_valid from cycle 17, tt_out=16'hF000.
REQ-033 Mid-sweep reset: rst_n low at cycle 9 -> pi=0, busy=0, tt_out=0 immediately; a new start after release -> correct 16'hF000 result.
REQ-034 Busy start: start re-pulsed at cycle 5 -> sweep timing and result unchanged from REQ-029.
